// File: rtl/rf_cmd_writer_if.sv
// Host-byte-stream and register-file write bus seen by the command writer.
// Latency: none, this is wiring only.
// Backpressure: rx_ready throttles the byte stream, ready_rf throttles register writes.
interface rf_cmd_writer_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       we_rf;
    logic [7:0] addr_rf;
    logic [7:0] data_rf;
    logic       ready_rf;
    logic       cmd_done;
    logic       cmd_err;
    logic [1:0] err_code;
    logic [7:0] cmd_count;

    // Writer side: consumes bytes, initiates register writes.
    modport master (
        input  rx_data, rx_valid, ready_rf,
        output rx_ready, we_rf, addr_rf, data_rf, cmd_done, cmd_err, err_code, cmd_count
    );

    // Peer side: host receiver plus register file.
    modport slave (
        output rx_data, rx_valid, ready_rf,
        input  rx_ready, we_rf, addr_rf, data_rf, cmd_done, cmd_err, err_code, cmd_count
    );
endinterface

// File: rtl/rf_cmd_writer.sv
// Parses SYNC/ADDR/DATA/CHK frames and issues one checked register-file write per frame.
// Latency: we_rf rises on the edge that accepts CHK; cmd_done/cmd_err pulse one cycle after the deciding edge.
// Backpressure: rx_ready drops while a write waits for ready_rf; we_rf/addr_rf/data_rf are held until accepted.
module rf_cmd_writer #(
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter logic [7:0]  ADDR_MIN     = 8'h20,
    parameter logic [7:0]  ADDR_MAX     = 8'h24,
    parameter logic [15:0] BYTE_TIMEOUT = 16'd1000
) (
    input  logic          SYS_CLK,
    input  logic          SYS_RST,
    rf_cmd_writer_if.master bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_ADDR = 3'd1,
        GET_DATA = 3'd2,
        GET_CHK  = 3'd3,
        WRITE    = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  addr_lat_q, addr_lat_d;
    logic [7:0]  data_lat_q, data_lat_d;
    logic        we_q, we_d;
    logic [7:0]  addr_rf_q, addr_rf_d;
    logic [7:0]  data_rf_q, data_rf_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] tmo_q, tmo_d;

    logic        accept;
    logic        tmo_hit;

    // Only the write-wait state refuses bytes.
    assign bus.rx_ready = (state_q != WRITE);
    assign accept       = bus.rx_valid && bus.rx_ready;
    // Counter reaches the limit on this edge unless a byte arrives.
    assign tmo_hit      = (tmo_q == BYTE_TIMEOUT - 16'd1);

    assign bus.we_rf     = we_q;
    assign bus.addr_rf   = addr_rf_q;
    assign bus.data_rf   = data_rf_q;
    assign bus.cmd_done  = done_q;
    assign bus.cmd_err   = err_q;
    assign bus.err_code  = err_code_q;
    assign bus.cmd_count = cnt_q;

    // Frame parser: next state, latches, pulses and idle-byte timeout.
    always_comb begin
        state_d    = state_q;
        addr_lat_d = addr_lat_q;
        data_lat_d = data_lat_q;
        we_d       = we_q;
        addr_rf_d  = addr_rf_q;
        data_rf_d  = data_rf_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        cnt_d      = cnt_q;
        tmo_d      = 16'd0;

        case (state_q)
            IDLE: begin
                if (accept && (bus.rx_data == SYNC_BYTE)) begin
                    state_d = GET_ADDR;
                end
            end
            GET_ADDR, GET_DATA, GET_CHK: begin
                if (accept) begin
                    if (state_q == GET_ADDR) begin
                        addr_lat_d = bus.rx_data;
                        state_d    = GET_DATA;
                    end else if (state_q == GET_DATA) begin
                        data_lat_d = bus.rx_data;
                        state_d    = GET_CHK;
                    end else if (bus.rx_data != (addr_lat_q ^ data_lat_q)) begin
                        // Checksum is judged first so it wins over a bad address.
                        err_d      = 1'b1;
                        err_code_d = 2'b01;
                        state_d    = IDLE;
                    end else if ((addr_lat_q < ADDR_MIN) || (addr_lat_q > ADDR_MAX)) begin
                        err_d      = 1'b1;
                        err_code_d = 2'b10;
                        state_d    = IDLE;
                    end else begin
                        we_d      = 1'b1;
                        addr_rf_d = addr_lat_q;
                        data_rf_d = data_lat_q;
                        state_d   = WRITE;
                    end
                end else if (tmo_hit) begin
                    err_d      = 1'b1;
                    err_code_d = 2'b11;
                    state_d    = IDLE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            WRITE: begin
                if (bus.ready_rf) begin
                    we_d    = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                    state_d = IDLE;
                end
            end
            default: begin
                we_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops we_rf without waiting for a clock.
    always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
        if (SYS_RST) begin
            state_q    <= IDLE;
            addr_lat_q <= 8'h00;
            data_lat_q <= 8'h00;
            we_q       <= 1'b0;
            addr_rf_q  <= 8'h00;
            data_rf_q  <= 8'h00;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            cnt_q      <= 8'h00;
            tmo_q      <= 16'd0;
        end else begin
            state_q    <= state_d;
            addr_lat_q <= addr_lat_d;
            data_lat_q <= data_lat_d;
            we_q       <= we_d;
            addr_rf_q  <= addr_rf_d;
            data_rf_q  <= data_rf_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
        end
    end

endmodule

// File: tb/tb_rf_cmd_writer.sv
// Directed and randomized frames against a frame-level reference model.
// Latency: checks the CHK-to-we_rf and commit-to-cmd_done timing directly.
// Backpressure: stalls ready_rf and verifies the write is held and rx_ready stays low.
module tb_rf_cmd_writer;
    logic clk;
    logic rst;

    rf_cmd_writer_if bus ();

    rf_cmd_writer dut (
        .SYS_CLK (clk),
        .SYS_RST (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Monitor tallies (only the monitor process writes these).
    int         n_wr = 0, n_done = 0, n_err = 0;
    int         wcur = 0, we_len = 0;
    int         unstable = 0, rdy_viol = 0, both_hi = 0;
    logic [7:0] last_wa = 8'h00, last_wd = 8'h00, hold_a = 8'h00, hold_d = 8'h00;

    // Reference-model state.
    logic [7:0] exp_cnt;
    logic [1:0] exp_ec;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame outcome from the rules: 0 write, 1 checksum error, 2 range error.
    function automatic int model_kind(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        if (c != (a ^ d)) return 1;
        if (a < 8'h20 || a > 8'h24) return 2;
        return 0;
    endfunction

    // Event monitor sampling on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.we_rf) begin
                    if (wcur > 0 && (bus.addr_rf != hold_a || bus.data_rf != hold_d)) unstable++;
                    hold_a = bus.addr_rf;
                    hold_d = bus.data_rf;
                    wcur++;
                    if (bus.rx_ready) rdy_viol++;
                    if (bus.ready_rf) begin
                        n_wr++;
                        last_wa = bus.addr_rf;
                        last_wd = bus.data_rf;
                    end
                end else if (wcur > 0) begin
                    we_len = wcur;
                    wcur   = 0;
                end
                if (bus.cmd_done) n_done++;
                if (bus.cmd_err) n_err++;
                if (bus.cmd_done && bus.cmd_err) both_hi++;
            end
        end
    end

    task automatic idle(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    // Present one byte and hold it until the writer takes it.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        while (!bus.rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rx_accept", 32'(n < 50), 32'd1);
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c,
                             input int stall, input int njunk, input int gap);
        int w0, d0, e0, kind;
        logic [7:0] jb;
        kind = model_kind(a, d, c);
        w0 = n_wr; d0 = n_done; e0 = n_err;
        bus.ready_rf = 1'b0;
        repeat (njunk) begin
            jb = 8'($urandom_range(0, 255));
            if (jb == 8'hA5) jb = 8'h00;
            send_byte(jb);
        end
        send_byte(8'hA5); idle(gap);
        send_byte(a);     idle(gap);
        send_byte(d);     idle(gap);
        send_byte(c);
        idle(stall);
        bus.ready_rf = 1'b1;
        idle(3);
        if (kind == 0) begin
            exp_cnt = exp_cnt + 8'd1;
            check("fr_wr",     32'(n_wr - w0),   32'd1);
            check("fr_done",   32'(n_done - d0), 32'd1);
            check("fr_noerr",  32'(n_err - e0),  32'd0);
            check("fr_addr",   32'(last_wa),     32'(a));
            check("fr_data",   32'(last_wd),     32'(d));
            check("fr_we_len", 32'(we_len),      32'(stall + 1));
        end else begin
            exp_ec = 2'(kind);
            check("fr_nowr",   32'(n_wr - w0),   32'd0);
            check("fr_nodone", 32'(n_done - d0), 32'd0);
            check("fr_err",    32'(n_err - e0),  32'd1);
        end
        check("fr_ec",  32'(bus.err_code),  32'(exp_ec));
        check("fr_cnt", 32'(bus.cmd_count), 32'(exp_cnt));
    endtask

    initial begin
        int e0, w0, d0;
        logic [7:0] a, d, c, x;

        exp_cnt = 8'h00;
        exp_ec  = 2'b00;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.ready_rf = 1'b1;
        rst = 1'b1;
        #1;
        check("rst_we",    32'(bus.we_rf),     32'd0);
        check("rst_addr",  32'(bus.addr_rf),   32'd0);
        check("rst_data",  32'(bus.data_rf),   32'd0);
        check("rst_done",  32'(bus.cmd_done),  32'd0);
        check("rst_err",   32'(bus.cmd_err),   32'd0);
        check("rst_ec",    32'(bus.err_code),  32'd0);
        check("rst_cnt",   32'(bus.cmd_count), 32'd0);
        check("rst_rdy",   32'(bus.rx_ready),  32'd1);
        #22;
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic write with exact latency.
        e0 = n_err;
        send_byte(8'hA5); send_byte(8'h21); send_byte(8'h3C); send_byte(8'h1D);
        @(negedge clk);
        check("lat_we",   32'(bus.we_rf),    32'd1);
        check("lat_addr", 32'(bus.addr_rf),  32'h21);
        check("lat_data", 32'(bus.data_rf),  32'h3C);
        check("lat_rdy",  32'(bus.rx_ready), 32'd0);
        check("lat_nodn", 32'(bus.cmd_done), 32'd0);
        @(negedge clk);
        check("lat_we0",  32'(bus.we_rf),     32'd0);
        check("lat_done", 32'(bus.cmd_done),  32'd1);
        check("lat_cnt",  32'(bus.cmd_count), 32'd1);
        @(negedge clk);
        check("lat_done1", 32'(bus.cmd_done), 32'd0);
        check("lat_noerr", 32'(n_err - e0),   32'd0);
        exp_cnt = 8'd1;
        @(posedge clk); #1;

        // Checksum error, range error, both (checksum wins).
        run_frame(8'h20, 8'h05, 8'h00, 0, 0, 0);
        run_frame(8'h30, 8'h01, 8'h31, 0, 0, 0);
        run_frame(8'h30, 8'h01, 8'h00, 0, 0, 0);
        // Leading junk, then upper-boundary address; lower boundary too.
        send_byte(8'h00); send_byte(8'hFF);
        run_frame(8'h24, 8'h80, 8'hA4, 0, 0, 0);
        run_frame(8'h20, 8'h11, 8'h31, 0, 0, 0);
        // SYNC value used as an address is out of range, not a resync.
        run_frame(8'hA5, 8'h00, 8'hA5, 0, 0, 0);

        // A byte just before the timeout limit is still accepted.
        bus.ready_rf = 1'b1;
        e0 = n_err; w0 = n_wr;
        send_byte(8'hA5); send_byte(8'h22);
        idle(999);
        check("tmo_early", 32'(n_err - e0), 32'd0);
        send_byte(8'h0F); send_byte(8'h2D);
        idle(3);
        exp_cnt = exp_cnt + 8'd1;
        check("tmo_bw_wr",  32'(n_wr - w0),   32'd1);
        check("tmo_bw_err", 32'(n_err - e0),  32'd0);
        check("tmo_bw_adr", 32'(last_wa),     32'h22);
        // Stalled frame times out.
        send_byte(8'hA5); send_byte(8'h22);
        idle(1010);
        exp_ec = 2'b11;
        check("tmo_err",  32'(n_err - e0),    32'd1);
        check("tmo_ec",   32'(bus.err_code),  32'd3);
        check("tmo_idle", 32'(bus.rx_ready),  32'd1);
        run_frame(8'h22, 8'h0F, 8'h2D, 0, 0, 0);

        // ready_rf held low for 5 cycles.
        run_frame(8'h23, 8'h5A, 8'h79, 5, 0, 0);

        // Randomized frames with junk, gaps and stalls.
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom_range(8'h1C, 8'h28));
            d = 8'($urandom);
            c = a ^ d;
            if ($urandom_range(0, 9) < 3) begin
                x = 8'($urandom_range(1, 255));
                c = c ^ x;
            end
            run_frame(a, d, c, int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
                      int'($urandom_range(0, 3)));
        end

        // Reset while a write is pending.
        bus.ready_rf = 1'b0;
        send_byte(8'hA5); send_byte(8'h23); send_byte(8'h11); send_byte(8'h32);
        @(negedge clk);
        check("mid_we_pre", 32'(bus.we_rf), 32'd1);
        #2;
        d0 = n_done;
        rst = 1'b1;
        #1;
        check("mid_we",   32'(bus.we_rf),     32'd0);
        check("mid_addr", 32'(bus.addr_rf),   32'd0);
        check("mid_data", 32'(bus.data_rf),   32'd0);
        check("mid_ec",   32'(bus.err_code),  32'd0);
        check("mid_cnt",  32'(bus.cmd_count), 32'd0);
        check("mid_rdy",  32'(bus.rx_ready),  32'd1);
        #6;
        rst = 1'b0;
        exp_cnt = 8'h00;
        exp_ec  = 2'b00;
        @(posedge clk); #1;
        bus.ready_rf = 1'b1;
        idle(5);
        check("mid_nodone", 32'(n_done - d0), 32'd0);

        // 256 valid frames wrap the counter back to zero.
        for (int i = 0; i < 256; i++) begin
            a = 8'($urandom_range(8'h20, 8'h24));
            d = 8'($urandom);
            run_frame(a, d, a ^ d, 0, 0, 0);
        end
        check("wrap_cnt", 32'(bus.cmd_count), 32'd0);

        check("excl_done_err", 32'(both_hi),  32'd0);
        check("we_stable",     32'(unstable), 32'd0);
        check("rdy_low_write", 32'(rdy_viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #2000000;
        $display("FAIL sim_timeout: observed no finish, expected finish");
        $fatal(1, "time limit");
    end
endmodule
